// File: rtl/digit_serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM encoding, the full-adder cell
// and the elaboration-time parameter check.
package digit_serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Returns {carry_out, sum}
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
        return {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
    endfunction

    function automatic bit digit_ok(input int width, input int digit);
        return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/digit_serial_adder_rca_slice.sv
// Combinational DIGIT-wide ripple-carry slice; also exposes the carry into its top bit
// so the caller can form signed overflow on the final digit.
module rca_slice
    import digit_serial_adder_pkg::*;
#(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_cin,
    output logic [DIGIT-1:0] o_sum,
    output logic             o_cout,
    output logic             o_c_msb
);

    logic [DIGIT:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar g = 0; g < DIGIT; g++) begin : g_bit
        assign {w_c[g+1], o_sum[g]} = full_add(i_a[g], i_b[g], w_c[g]);
    end

    assign o_cout  = w_c[DIGIT];
    assign o_c_msb = w_c[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock with a registered carry,
// START/DONE handshake, results published only on completion.
module digit_serial_adder
    import digit_serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    input  logic             SUB,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] F,
    output logic             COUT,
    output logic             OVF
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if (!digit_ok(WIDTH, DIGIT)) begin : g_param_check
        $error("digit_serial_adder: DIGIT must be >= 1 and divide WIDTH");
    end

    state_t            r_state;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_be;
    logic [WIDTH-1:0]  r_sum;
    logic              r_carry;
    logic [CNT_W-1:0]  r_cnt;

    logic [IDX_W-1:0]  w_base;
    logic [DIGIT-1:0]  w_sum;
    logic              w_cout;
    logic              w_c_msb;
    logic              w_last;
    logic [WIDTH-1:0]  w_full;

    assign w_base = IDX_W'(r_cnt) * IDX_W'(DIGIT);
    assign w_last = (r_cnt == CNT_W'(N - 1));

    rca_slice #(
        .DIGIT (DIGIT)
    ) u_slice (
        .i_a     (r_a[w_base +: DIGIT]),
        .i_b     (r_be[w_base +: DIGIT]),
        .i_cin   (r_carry),
        .o_sum   (w_sum),
        .o_cout  (w_cout),
        .o_c_msb (w_c_msb)
    );

    // Completed sum as it will look once the current slice is written back
    always_comb begin
        w_full                  = r_sum;
        w_full[w_base +: DIGIT] = w_sum;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_be    <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            F       <= '0;
            COUT    <= 1'b0;
            OVF     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        r_a     <= A;
                        r_be    <= SUB ? ~B : B;
                        r_carry <= SUB ^ CIN;
                        r_cnt   <= '0;
                        BUSY    <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_sum[w_base +: DIGIT] <= w_sum;
                    r_carry                <= w_cout;
                    r_cnt                  <= r_cnt + 1'b1;
                    if (w_last) begin
                        F       <= w_full;
                        COUT    <= w_cout;
                        OVF     <= w_cout ^ w_c_msb;
                        BUSY    <= 1'b0;
                        DONE    <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= ST_DONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed bench for digit_serial_adder (8,2) plus an operand sweep across several
// (WIDTH,DIGIT) builds compared against a behavioural model.
module tb_digit_serial_adder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        cin;
    logic        sub;
    logic        busy;
    logic        done;
    logic [7:0]  f;
    logic        cout;
    logic        ovf;

    logic        s_start;
    logic [15:0] s_a;
    logic [15:0] s_b;
    logic        s_cin;
    logic        s_sub;

    logic        d2_busy, d2_done, d2_cout, d2_ovf;
    logic [7:0]  d2_f;
    logic        d1_busy, d1_done, d1_cout, d1_ovf;
    logic [7:0]  d1_f;
    logic        d8_busy, d8_done, d8_cout, d8_ovf;
    logic [7:0]  d8_f;
    logic        d16_busy, d16_done, d16_cout, d16_ovf;
    logic [15:0] d16_f;

    int n_chk  = 0;
    int n_pass = 0;

    digit_serial_adder #(.WIDTH(8), .DIGIT(2)) u_dut (
        .CLK(clk), .RST_N(rst_n), .START(start), .A(a), .B(b), .CIN(cin), .SUB(sub),
        .BUSY(busy), .DONE(done), .F(f), .COUT(cout), .OVF(ovf)
    );

    digit_serial_adder #(.WIDTH(8), .DIGIT(2)) u_sw2 (
        .CLK(clk), .RST_N(rst_n), .START(s_start), .A(s_a[7:0]), .B(s_b[7:0]), .CIN(s_cin),
        .SUB(s_sub), .BUSY(d2_busy), .DONE(d2_done), .F(d2_f), .COUT(d2_cout), .OVF(d2_ovf)
    );

    digit_serial_adder #(.WIDTH(8), .DIGIT(1)) u_sw1 (
        .CLK(clk), .RST_N(rst_n), .START(s_start), .A(s_a[7:0]), .B(s_b[7:0]), .CIN(s_cin),
        .SUB(s_sub), .BUSY(d1_busy), .DONE(d1_done), .F(d1_f), .COUT(d1_cout), .OVF(d1_ovf)
    );

    digit_serial_adder #(.WIDTH(8), .DIGIT(8)) u_sw8 (
        .CLK(clk), .RST_N(rst_n), .START(s_start), .A(s_a[7:0]), .B(s_b[7:0]), .CIN(s_cin),
        .SUB(s_sub), .BUSY(d8_busy), .DONE(d8_done), .F(d8_f), .COUT(d8_cout), .OVF(d8_ovf)
    );

    digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_sw16 (
        .CLK(clk), .RST_N(rst_n), .START(s_start), .A(s_a), .B(s_b), .CIN(s_cin),
        .SUB(s_sub), .BUSY(d16_busy), .DONE(d16_done), .F(d16_f), .COUT(d16_cout), .OVF(d16_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Returns {14'b0, ovf, cout, f[15:0]} for a w-bit add/subtract
    function automatic logic [31:0] model(input int w, input logic [15:0] ma,
                                          input logic [15:0] mb, input logic mc, input logic ms);
        logic [16:0] mask, be, s;
        logic [15:0] fr;
        logic        ci, co, ov;
        mask = (17'd1 << w) - 17'd1;
        be   = {1'b0, (ms ? ~mb : mb)} & mask;
        ci   = ms ? ~mc : mc;
        s    = {1'b0, ma} + be + {16'b0, ci};
        fr   = s[15:0] & mask[15:0];
        co   = s[w];
        ov   = (ma[w-1] == be[w-1]) && (fr[w-1] != ma[w-1]);
        return {14'b0, ov, co, fr};
    endfunction

    task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                         input logic tc, input logic ts, input logic [7:0] ef,
                         input logic ec, input logic eo);
        int nb;
        @(negedge clk);
        a = ta; b = tb; cin = tc; sub = ts; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nb = 0;
        while (busy && nb < 20) begin
            nb++;
            @(negedge clk);
        end
        check({tag, ".busy_cycles"}, 32'(nb), 32'd4);
        check({tag, ".done"}, {31'b0, done}, 32'd1);
        check({tag, ".f"}, {24'b0, f}, {24'b0, ef});
        check({tag, ".cout"}, {31'b0, cout}, {31'b0, ec});
        check({tag, ".ovf"}, {31'b0, ovf}, {31'b0, eo});
        @(negedge clk);
        check({tag, ".done_pulse"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        int         done_at [2];
        logic [7:0] f_at [2];
        int         nd;
        int         seen;
        logic [3:0] got;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        s_start = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.busy", {31'b0, busy}, 32'd0);
        check("rst.done", {31'b0, done}, 32'd0);
        check("rst.f", {24'b0, f}, 32'd0);
        check("rst.cout_ovf", {30'b0, cout, ovf}, 32'd0);
        rst_n = 1'b1;

        do_op("add_basic", 8'h3C, 8'h41, 1'b0, 1'b0, 8'h7D, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("hold.f", {24'b0, f}, 32'h7D);
        do_op("add_carry", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        do_op("add_ovf", 8'h7F, 8'h01, 1'b1, 1'b0, 8'h81, 1'b0, 1'b1);
        do_op("sub_neg", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);

        // START held high: second op is accepted in the DONE cycle with new operands
        nd = 0;
        @(negedge clk);
        a = 8'h11; b = 8'h22; cin = 1'b0; sub = 1'b0; start = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (i == 1) begin
                a = 8'h55; b = 8'h66;
            end
            if (done && nd < 2) begin
                done_at[nd] = i;
                f_at[nd]    = f;
                nd++;
            end
        end
        start = 1'b0;
        check("b2b.count", 32'(nd), 32'd2);
        check("b2b.first_at", 32'(done_at[0]), 32'd4);
        check("b2b.spacing", 32'(done_at[1] - done_at[0]), 32'd5);
        check("b2b.first_f", {24'b0, f_at[0]}, 32'h33);
        check("b2b.second_f", {24'b0, f_at[1]}, 32'hBB);
        repeat (3) @(negedge clk);

        do_op("sub_ovf", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

        // Reset asserted during the second RUN cycle
        @(negedge clk);
        a = 8'h10; b = 8'h20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst.busy", {31'b0, busy}, 32'd0);
        check("midrst.done", {31'b0, done}, 32'd0);
        check("midrst.f", {24'b0, f}, 32'd0);
        check("midrst.cout_ovf", {30'b0, cout, ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check("midrst.no_done", 32'(seen), 32'd0);
        do_op("after_rst", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);

        for (int ia = 0; ia < 32; ia++) begin
            for (int ib = 0; ib < 32; ib++) begin
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    s_a = 16'(ia); s_b = 16'(ib); s_cin = k[0]; s_sub = k[1]; s_start = 1'b1;
                    @(negedge clk);
                    s_start = 1'b0;
                    got = 4'b0;
                    for (int g = 0; g < 16 && got != 4'hF; g++) begin
                        if (d2_done && !got[0]) begin
                            got[0] = 1'b1;
                            check("swp8x2", {14'b0, d2_ovf, d2_cout, 8'h00, d2_f},
                                  model(8, s_a, s_b, s_cin, s_sub));
                        end
                        if (d1_done && !got[1]) begin
                            got[1] = 1'b1;
                            check("swp8x1", {14'b0, d1_ovf, d1_cout, 8'h00, d1_f},
                                  model(8, s_a, s_b, s_cin, s_sub));
                        end
                        if (d8_done && !got[2]) begin
                            got[2] = 1'b1;
                            check("swp8x8", {14'b0, d8_ovf, d8_cout, 8'h00, d8_f},
                                  model(8, s_a, s_b, s_cin, s_sub));
                        end
                        if (d16_done && !got[3]) begin
                            got[3] = 1'b1;
                            check("swp16x4", {14'b0, d16_ovf, d16_cout, d16_f},
                                  model(16, s_a, s_b, s_cin, s_sub));
                        end
                        if (got != 4'hF) @(negedge clk);
                    end
                    if (got != 4'hF) check("swp.timeout", {28'b0, got}, 32'hF);
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
